icc_branch_unit: RTL and testbench
==================================

Name: icc_branch_unit

Overview:
- Consumer end of the ALU condition-code outputs. Holds the integer condition codes (icc: N, Z, V, C).
- Returns the registered C bit to the ALU as carry-in for addx/subx/addxcc/subxcc.
- Evaluates the 16 SPARC Bicc conditions and resolves the delay-slot annul rules with a small FSM.
- Sits between the ALU and the fetch/nPC logic.

Parameters:
- ICC_RESET, 4'b0000, reset value of the {N,Z,V,C} register.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  the instruction in this stage is real. All state advances only when this is 1.
- icc_we  input  1  the current ALU operation modifies icc (alu_operation[4] of a cc op)
- n_in, z_in, v_in, c_in  input  1 each  flags from the ALU for the current operation
- is_bicc  input  1  the current instruction is a Bicc
- cond  input  4  Bicc cond field
- annul_bit  input  1  Bicc a bit
- icc  output  4  registered {N,Z,V,C}
- carry_out  output  1  icc[0], the carry-in to the ALU
- branch_taken  output  1  combinational; the current Bicc is taken
- annul_slot  output  1  combinational; the current instruction is squashed
- dcti_err  output  1  registered one-cycle pulse; a Bicc was found in a delay slot

Behaviour:
- Reset (async, rst_n=0): icc=ICC_RESET, FSM=NORMAL, dcti_err=0. Combinational outputs are 0 whenever instr_valid=0.
- icc write:
  - Condition: instr_valid & icc_we & ~annul_slot.
  - On that condition, icc<={n_in,z_in,v_in,c_in} at the next rising edge.
  - Otherwise icc holds.
  - Latency is 1 cycle. carry_out reflects the new value the cycle after the write.
- Condition evaluation uses registered icc (without the optional feature):
  - 0000 BN: 0
  - 0001 BE: Z
  - 0010 BLE: Z|(N^V)
  - 0011 BL: N^V
  - 0100 BLEU: C|Z
  - 0101 BCS: C
  - 0110 BNEG: N
  - 0111 BVS: V
  - 1000 BA: 1
  - 1001–1111 (BNE, BG, BGE, BGU, BCC, BPOS, BVC): logical complement of 0001–0111 respectively
- branch_taken = instr_valid & is_bicc & ~annul_slot & state==NORMAL & cond_true.
- FSM states: NORMAL, DELAY, ANNUL. Transitions occur only on instr_valid=1; with instr_valid=0 the state holds, covering stalls of any length.
- From NORMAL, with a valid Bicc:
  - annul_bit=1 and (cond==BA or ~cond_true): ->ANNUL.
  - Otherwise: ->DELAY.
  - Non-branch instruction: stay in NORMAL.
- ANNUL:
  - annul_slot=1 for the current instruction.
  - Its icc write is suppressed and its is_bicc is ignored.
  - Next state is NORMAL.
- DELAY:
  - The delay slot executes normally, including its icc write.
  - If is_bicc=1: branch_taken=0, dcti_err pulses the next cycle, and the state goes to NORMAL.
  - Next state is NORMAL.
- Simultaneous icc_we and is_bicc in one instruction cannot occur; if asserted, the branch uses the old icc and the write still occurs.
- Reset mid-sequence (in DELAY or ANNUL) returns to NORMAL, so the pending annul is lost.

Optional Feature:
- Macro ICC_BYPASS_EN.
- When defined: an extra input set fw_we and fw_n, fw_z, fw_v, fw_c carries the flags of the older instruction in execute.
  - If fw_we=1, condition evaluation uses the fw_* flags instead of registered icc.
  - carry_out is likewise bypassed.
- When undefined: these ports are absent and evaluation uses registered icc only.

Decomposition:
- Package icc_pkg:
  - cond encodings (COND_BN..COND_BVC)
  - FSM state enum {ST_NORMAL, ST_DELAY, ST_ANNUL}
  - icc bit indices (ICC_N=3, ICC_Z=2, ICC_V=1, ICC_C=0)
- One combinational sub-module, icc_cond_eval(icc, cond -> cond_true), shared with future FBfcc/Ticc logic.

Test Plan:
- Reset: set rst_n=0 mid-DELAY -> icc=0000, carry_out=0, annul_slot=0, and the next Bicc is evaluated from NORMAL.
- icc write then BE:
  - subcc writes {0,1,0,0} (icc_we=1).
  - Next cycle, cond=0001 -> branch_taken=1 and state goes to DELAY.
  - The slot instruction has annul_slot=0.
- BNE,a untaken: icc Z=1, cond=1001, annul_bit=1 -> branch_taken=0; the next valid instruction has annul_slot=1 and its icc_we=1 does not change icc.
- BA,a: cond=1000, annul_bit=1 -> branch_taken=1 and the delay slot has annul_slot=1. BN (cond=0000, annul_bit=0) -> branch_taken=0 and the slot executes.
- Stall plus carry:
  - addcc yields C=1, so carry_out=1 the next cycle.
  - Three cycles with instr_valid=0 after a BCS,a untaken leave the FSM in ANNUL; the squash applies on the first valid instruction.
- DCTI couple: a Bicc in DELAY -> branch_taken=0, dcti_err=1 for exactly one cycle. With ICC_BYPASS_EN, fw_we=1 and fw_z=1 make BE taken while registered Z=0.

Source files
------------

// File: rtl/icc_pkg.sv
// Shared encodings for the integer condition-code unit: Bicc cond field, annul FSM states, icc bit positions.
package icc_pkg;

    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;

    typedef enum logic [3:0] {
        COND_BN   = 4'b0000,
        COND_BE   = 4'b0001,
        COND_BLE  = 4'b0010,
        COND_BL   = 4'b0011,
        COND_BLEU = 4'b0100,
        COND_BCS  = 4'b0101,
        COND_BNEG = 4'b0110,
        COND_BVS  = 4'b0111,
        COND_BA   = 4'b1000,
        COND_BNE  = 4'b1001,
        COND_BG   = 4'b1010,
        COND_BGE  = 4'b1011,
        COND_BGU  = 4'b1100,
        COND_BCC  = 4'b1101,
        COND_BPOS = 4'b1110,
        COND_BVC  = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ANNUL  = 2'd2
    } state_e;

endpackage

// File: rtl/icc_branch_unit_if.sv
// ALU/fetch-side bundle for the icc branch unit; fw_* flags exist only when ICC_BYPASS_EN is defined.
interface icc_branch_unit_if;
    logic       instr_valid;
    logic       icc_we;
    logic       n_in;
    logic       z_in;
    logic       v_in;
    logic       c_in;
    logic       is_bicc;
    logic [3:0] cond;
    logic       annul_bit;
`ifdef ICC_BYPASS_EN
    logic       fw_we;
    logic       fw_n;
    logic       fw_z;
    logic       fw_v;
    logic       fw_c;
`endif
    logic [3:0] icc;
    logic       carry_out;
    logic       branch_taken;
    logic       annul_slot;
    logic       dcti_err;

    modport master (
        output instr_valid, icc_we, n_in, z_in, v_in, c_in, is_bicc, cond, annul_bit,
`ifdef ICC_BYPASS_EN
        output fw_we, fw_n, fw_z, fw_v, fw_c,
`endif
        input  icc, carry_out, branch_taken, annul_slot, dcti_err
    );

    modport slave (
        input  instr_valid, icc_we, n_in, z_in, v_in, c_in, is_bicc, cond, annul_bit,
`ifdef ICC_BYPASS_EN
        input  fw_we, fw_n, fw_z, fw_v, fw_c,
`endif
        output icc, carry_out, branch_taken, annul_slot, dcti_err
    );
endinterface

// File: rtl/icc_cond_eval.sv
// Evaluates a 4-bit Bicc-style cond field against {N,Z,V,C}.
// Latency: purely combinational. Backpressure: none.
module icc_cond_eval
    import icc_pkg::*;
(
    input  logic [3:0] icc,
    input  logic [3:0] cond,
    output logic       cond_true
);
    logic base;

    // Upper half of the encoding is the complement of the lower half (BN -> BA, BE -> BNE, ...).
    always_comb begin
        base = 1'b0;
        case (cond[2:0])
            3'd0: base = 1'b0;
            3'd1: base = icc[ICC_Z];
            3'd2: base = icc[ICC_Z] | (icc[ICC_N] ^ icc[ICC_V]);
            3'd3: base = icc[ICC_N] ^ icc[ICC_V];
            3'd4: base = icc[ICC_C] | icc[ICC_Z];
            3'd5: base = icc[ICC_C];
            3'd6: base = icc[ICC_N];
            3'd7: base = icc[ICC_V];
            default: base = 1'b0;
        endcase
    end

    assign cond_true = cond[3] ? ~base : base;
endmodule

// File: rtl/icc_branch_unit.sv
// Holds icc, feeds carry back to the ALU, resolves Bicc taken/annul; optional ICC_BYPASS_EN forwards execute-stage flags.
// Latency: icc, dcti_err one cycle; branch_taken, annul_slot combinational on the current instruction.
// Backpressure: none; instr_valid=0 freezes all state for stalls of any length.
module icc_branch_unit
    import icc_pkg::*;
#(
    parameter logic [3:0] ICC_RESET = 4'b0000
) (
    input  logic               clk,
    input  logic               rst_n,
    icc_branch_unit_if.slave   bus
);
    state_e     state_q, state_d;
    logic [3:0] icc_q;
    logic [3:0] eval_icc;
    logic       cond_true;
    logic       annul_slot;
    logic       branch_taken;
    logic       dcti_d, dcti_q;

`ifdef ICC_BYPASS_EN
    assign eval_icc      = bus.fw_we ? {bus.fw_n, bus.fw_z, bus.fw_v, bus.fw_c} : icc_q;
    assign bus.carry_out = bus.fw_we ? bus.fw_c : icc_q[ICC_C];
`else
    assign eval_icc      = icc_q;
    assign bus.carry_out = icc_q[ICC_C];
`endif

    icc_cond_eval u_cond_eval (
        .icc       (eval_icc),
        .cond      (bus.cond),
        .cond_true (cond_true)
    );

    always_comb begin
        state_d      = state_q;
        annul_slot   = 1'b0;
        branch_taken = 1'b0;
        dcti_d       = 1'b0;
        if (bus.instr_valid) begin
            case (state_q)
                ST_NORMAL: begin
                    if (bus.is_bicc) begin
                        branch_taken = cond_true;
                        if (bus.annul_bit && (bus.cond == COND_BA || !cond_true))
                            state_d = ST_ANNUL;
                        else
                            state_d = ST_DELAY;
                    end
                end
                // A branch in the delay slot is a DCTI couple: flag it and never take it.
                ST_DELAY: begin
                    dcti_d  = bus.is_bicc;
                    state_d = ST_NORMAL;
                end
                ST_ANNUL: begin
                    annul_slot = 1'b1;
                    state_d    = ST_NORMAL;
                end
                default: state_d = ST_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
            icc_q   <= ICC_RESET;
            dcti_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcti_q  <= dcti_d;
            if (bus.instr_valid && bus.icc_we && !annul_slot)
                icc_q <= {bus.n_in, bus.z_in, bus.v_in, bus.c_in};
        end
    end

    assign bus.icc          = icc_q;
    assign bus.branch_taken = branch_taken;
    assign bus.annul_slot   = annul_slot;
    assign bus.dcti_err     = dcti_q;
endmodule

// File: tb/tb_icc_branch_unit.sv
// Directed bench for icc_branch_unit: icc writes, Bicc evaluation, annul/delay FSM, stalls, DCTI couples, reset.
module tb_icc_branch_unit;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    icc_branch_unit_if bus ();

    icc_branch_unit #(.ICC_RESET(4'b0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one instruction and lets combinational outputs settle away from the clock edge.
    task automatic drive(input logic v, input logic we, input logic [3:0] f,
                         input logic b, input logic [3:0] c, input logic a);
        bus.instr_valid = v;
        bus.icc_we      = we;
        {bus.n_in, bus.z_in, bus.v_in, bus.c_in} = f;
        bus.is_bicc     = b;
        bus.cond        = c;
        bus.annul_bit   = a;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] tbl_cond [8];
        logic       tbl_exp  [8];
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
`ifdef ICC_BYPASS_EN
        bus.fw_we = 1'b0;
        {bus.fw_n, bus.fw_z, bus.fw_v, bus.fw_c} = 4'b0000;
`endif
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_icc", bus.icc, 4'b0000);
        chk("rst_carry", {3'b0, bus.carry_out}, 4'h0);
        chk("rst_dcti", {3'b0, bus.dcti_err}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // subcc writes Z, then BE is taken and its slot runs (slot is addcc producing C=1).
        drive(1'b1, 1'b1, 4'b0100, 1'b0, 4'h0, 1'b0);
        chk("subcc_annul", {3'b0, bus.annul_slot}, 4'h0);
        tick();
        chk("subcc_icc", bus.icc, 4'b0100);
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b0001, 1'b0);
        chk("be_taken", {3'b0, bus.branch_taken}, 4'h1);
        tick();
        drive(1'b1, 1'b1, 4'b0001, 1'b0, 4'h0, 1'b0);
        chk("be_slot_annul", {3'b0, bus.annul_slot}, 4'h0);
        tick();
        chk("addcc_icc", bus.icc, 4'b0001);
        chk("addcc_carry", {3'b0, bus.carry_out}, 4'h1);

        // BNE,a with Z=1: untaken, slot squashed including its icc write.
        drive(1'b1, 1'b1, 4'b0100, 1'b0, 4'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b1001, 1'b1);
        chk("bne_a_taken", {3'b0, bus.branch_taken}, 4'h0);
        tick();
        drive(1'b1, 1'b1, 4'b1111, 1'b0, 4'h0, 1'b0);
        chk("bne_a_slot_annul", {3'b0, bus.annul_slot}, 4'h1);
        tick();
        chk("bne_a_icc_held", bus.icc, 4'b0100);

        // BA,a: taken, slot squashed even though it is itself a Bicc.
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b1);
        chk("ba_a_taken", {3'b0, bus.branch_taken}, 4'h1);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b0);
        chk("ba_a_slot_annul", {3'b0, bus.annul_slot}, 4'h1);
        chk("ba_a_slot_taken", {3'b0, bus.branch_taken}, 4'h0);
        tick();
        chk("ba_a_no_dcti", {3'b0, bus.dcti_err}, 4'h0);

        // BN without annul: not taken, slot executes and writes icc.
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b0000, 1'b0);
        chk("bn_taken", {3'b0, bus.branch_taken}, 4'h0);
        tick();
        drive(1'b1, 1'b1, 4'b0001, 1'b0, 4'h0, 1'b0);
        chk("bn_slot_annul", {3'b0, bus.annul_slot}, 4'h0);
        tick();
        chk("bn_slot_icc", bus.icc, 4'b0001);

        // BCS,a untaken then a 3-cycle stall: squash lands on the first valid instruction.
        drive(1'b1, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b0101, 1'b1);
        chk("bcs_a_taken", {3'b0, bus.branch_taken}, 4'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 4'b1111, 1'b1, 4'b1000, 1'b0);
            chk("stall_annul", {3'b0, bus.annul_slot}, 4'h0);
            chk("stall_taken", {3'b0, bus.branch_taken}, 4'h0);
            tick();
        end
        chk("stall_icc_held", bus.icc, 4'b0000);
        drive(1'b1, 1'b1, 4'b1010, 1'b0, 4'h0, 1'b0);
        chk("post_stall_annul", {3'b0, bus.annul_slot}, 4'h1);
        tick();
        chk("post_stall_icc", bus.icc, 4'b0000);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("after_squash_annul", {3'b0, bus.annul_slot}, 4'h0);
        tick();

        // DCTI couple: Bicc in the delay slot is not taken and raises a one-cycle error.
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b0);
        chk("dcti_first_taken", {3'b0, bus.branch_taken}, 4'h1);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b0);
        chk("dcti_slot_taken", {3'b0, bus.branch_taken}, 4'h0);
        chk("dcti_pre", {3'b0, bus.dcti_err}, 4'h0);
        tick();
        chk("dcti_pulse", {3'b0, bus.dcti_err}, 4'h1);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        chk("dcti_clear", {3'b0, bus.dcti_err}, 4'h0);

        // Condition table against icc = N1 Z0 V1 C0; each branch followed by a plain slot.
        tbl_cond[0] = 4'b0010; tbl_exp[0] = 1'b0;  // BLE
        tbl_cond[1] = 4'b0011; tbl_exp[1] = 1'b0;  // BL
        tbl_cond[2] = 4'b1010; tbl_exp[2] = 1'b1;  // BG
        tbl_cond[3] = 4'b1011; tbl_exp[3] = 1'b1;  // BGE
        tbl_cond[4] = 4'b1100; tbl_exp[4] = 1'b1;  // BGU
        tbl_cond[5] = 4'b1110; tbl_exp[5] = 1'b0;  // BPOS
        tbl_cond[6] = 4'b0111; tbl_exp[6] = 1'b1;  // BVS
        tbl_cond[7] = 4'b1101; tbl_exp[7] = 1'b1;  // BCC
        drive(1'b1, 1'b1, 4'b1010, 1'b0, 4'h0, 1'b0);
        tick();
        chk("tbl_icc", bus.icc, 4'b1010);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b1, tbl_cond[i], 1'b0);
            chk($sformatf("cond_%0d", i), {3'b0, bus.branch_taken}, {3'b0, tbl_exp[i]});
            tick();
            drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
            tick();
        end

`ifdef ICC_BYPASS_EN
        // Registered Z=0, forwarded Z=1: BE taken from the forwarded flags.
        bus.fw_we = 1'b1;
        {bus.fw_n, bus.fw_z, bus.fw_v, bus.fw_c} = 4'b0101;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b0001, 1'b0);
        chk("fw_be_taken", {3'b0, bus.branch_taken}, 4'h1);
        chk("fw_carry", {3'b0, bus.carry_out}, 4'h1);
        tick();
        bus.fw_we = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
`endif

        // Reset asserted while in DELAY: icc cleared and the next Bicc is resolved from NORMAL.
        drive(1'b1, 1'b1, 4'b1111, 1'b0, 4'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b0);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("midrst_icc", bus.icc, 4'b0000);
        chk("midrst_carry", {3'b0, bus.carry_out}, 4'h0);
        chk("midrst_annul", {3'b0, bus.annul_slot}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b1);
        chk("postrst_ba_taken", {3'b0, bus.branch_taken}, 4'h1);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("postrst_slot_annul", {3'b0, bus.annul_slot}, 4'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
